dmem_arbiter: RTL
=================

# dmem_arbiter

Arbitrates the processor's single data memory port between two requesters: the CPU load/store path and the syscall I/O unit, which reads and writes buffers in data memory. Each access is sequenced as a multi-cycle transaction against a fixed-latency memory. The block returns a one-cycle completion pulse with read data, and drives a stall to the CPU while its request is pending. It sits between the CPU/`SYSCALL_controller` request paths and the data memory.

## Interface
- `DATA_W`, 32, data width
- `ADDR_W`, 32, address width
- `MEM_LAT`, 1, cycles from issue to valid `mem_rdata`; legal range 1..15
- `clock` in 1: sole clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `cpu_req` in 1: CPU request; held with attributes stable until `cpu_done`
- `cpu_we` in 1: 1 = write, 0 = read
- `cpu_addr` in ADDR_W: CPU address
- `cpu_wdata` in DATA_W: CPU write data
- `cpu_done` out 1: one-cycle completion pulse
- `cpu_stall` out 1: `cpu_req & ~cpu_done` (combinational)
- `sys_req`, `sys_we`, `sys_addr`, `sys_wdata` in: syscall-side equivalents of the CPU inputs
- `sys_done` out 1: one-cycle completion pulse
- `rdata` out DATA_W: read data; valid in the cycle a read's `done` is high
- `mem_addr` out ADDR_W: address to data memory
- `mem_wdata` out DATA_W: write data to data memory
- `mem_read` out 1: memory read enable
- `mem_write` out 1: memory write enable
- `mem_rdata` in DATA_W: data memory read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - Any request goes to ACCESS with the winner latched: `owner`, `we`, `addr`, `wdata`.
  - Counter loads `MEM_LAT-1`.
- **ACCESS**
  - `mem_addr` and `mem_wdata` are driven from the latched values.
  - Reads hold `mem_read` for all ACCESS cycles.
  - Writes assert `mem_write` only in the first ACCESS cycle, giving exactly one write per transaction.
  - The counter decrements each edge.
  - At the edge where the counter is 0:
    - For reads, `mem_rdata` is captured into `rdata`.
    - The FSM moves to RESP.
- **RESP**
  - The owner's `done` is 1.
  - Arbitration runs again with the current owner's request masked.
  - If the other requester is requesting, the FSM goes directly to ACCESS (back-to-back). Otherwise it returns to IDLE.
- **Arbitration**
  - Two-way round-robin.
  - With a single requester, that requester wins.
  - On a tie, the requester not in `last_grant` wins.
  - `last_grant` updates on every grant.
- Writes leave `rdata` unchanged.
- Requester protocol:
  - A requester drops `req` in the cycle after `done`, or re-asserts it for a new access.
  - Deasserting `req` before `done` is illegal. The bench checks this with an assertion; RTL behaviour in that case is undefined.
- **Reset** (async, any state, including mid-ACCESS):
  - State IDLE.
  - `cpu_done`, `sys_done`, `mem_read`, `mem_write` = 0.
  - `mem_addr`, `mem_wdata`, `rdata` = 0.
  - `last_grant` = SYS, so the CPU wins the first tie.
  - An aborted write is issued at most once. An aborted transaction never completes.

## Timing
- All outputs are registered except `cpu_stall`.
- The request is sampled at edge E0. ACCESS spans E0..E(MEM_LAT). `done` is high for the cycle following E(MEM_LAT).
- Request-to-done latency is MEM_LAT+1 edges.
- Throughput with both requesters continuously requesting is one transaction per MEM_LAT+1 cycles, with no idle bubble.
- A request arriving during RESP from the non-owner is granted at the RESP-ending edge.
- A request from the owner during RESP is ignored until the next arbitration.
- The counter is 4 bits wide and never wraps, because it is reloaded on every grant.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state encoding (IDLE/ACCESS/RESP)
  - requester IDs `REQ_CPU = 0`, `REQ_SYS = 1`
  - counter width constant 4
- Sub-module `rr_pick2` is combinational:
  - inputs: `req[1:0]`, `mask[1:0]`, `last_grant`
  - outputs: `grant_valid`, `grant_id`
- FSM, latches and counter live in `dmem_arbiter`.

## Test plan
- Reset, then CPU read of address 0x10 with memory holding 0xDEADBEEF at MEM_LAT=1 → `mem_read` high 1 cycle, `cpu_done` 2 cycles after request, `rdata` = 0xDEADBEEF, `cpu_stall` high exactly 2 cycles.
- SYS write of 0x12345678 to 0x20 at MEM_LAT=3 → `mem_write` high for exactly 1 cycle, `mem_read` never high, `sys_done` 4 cycles after request, later CPU read of 0x20 returns 0x12345678.
- CPU and SYS request in the same cycle after reset → CPU granted first, SYS granted at the CPU's RESP edge, `done` pulses 2 cycles apart at MEM_LAT=1, and grants alternate over 4 further transactions.
- CPU re-requests immediately after its `done` while SYS is idle → CPU is served again, ending with a RESP→IDLE→ACCESS sequence and no starvation check failure.
- `reset_n` asserted mid-ACCESS of a MEM_LAT=3 read → all outputs go to 0 asynchronously, no `done` follows, and a fresh CPU request after release completes normally.
- Write followed by read from different requesters → `rdata` holds the prior read value during the write's `done`.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, requester IDs
// and the latency counter type.
package dmem_arb_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_SYS = 1'b1;

    // One-hot bit of a requester, used to mask the current owner in RESP.
    function automatic logic [1:0] req_onehot(input logic id);
        logic [1:0] oh;
        if (id == REQ_SYS) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    logic [1:0] eff_s;

    // Select the winner among unmasked requesters.
    always_comb begin
        eff_s       = req & ~mask;
        grant_valid = 1'b0;
        grant_id    = REQ_CPU;
        case (eff_s)
            2'b01: begin
                grant_valid = 1'b1;
                grant_id    = REQ_CPU;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_id    = REQ_SYS;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end
            default: begin
                grant_valid = 1'b0;
                grant_id    = REQ_CPU;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU load/store path and the
// syscall I/O unit, sequencing each access against a fixed-latency memory.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
)
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              sys_req,
    input  logic              sys_we,
    input  logic [ADDR_W-1:0] sys_addr,
    input  logic [DATA_W-1:0] sys_wdata,
    output logic              sys_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam cnt_t CNT_LOAD = cnt_t'(MEM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    cnt_t              cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              cpu_done_q, cpu_done_d;
    logic              sys_done_q, sys_done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        mask_s;
    logic              grant_valid_s;
    logic              grant_id_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    // In RESP the owner is masked so the other side gets a back-to-back grant.
    always_comb begin
        if (state_q == ST_RESP) begin
            mask_s = req_onehot(owner_q);
        end else begin
            mask_s = 2'b00;
        end
    end

    rr_pick2 u_pick (
        .req         ({sys_req, cpu_req}),
        .mask        (mask_s),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    assign sel_we_s    = (grant_id_s == REQ_SYS) ? sys_we    : cpu_we;
    assign sel_addr_s  = (grant_id_s == REQ_SYS) ? sys_addr  : cpu_addr;
    assign sel_wdata_s = (grant_id_s == REQ_SYS) ? sys_wdata : cpu_wdata;

    // Next-state logic for the FSM, transaction latches and output registers.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        rdata_d      = rdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        cpu_done_d   = 1'b0;
        sys_done_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (grant_valid_s) begin
                    state_d      = ST_ACCESS;
                    owner_d      = grant_id_s;
                    last_grant_d = grant_id_s;
                    we_d         = sel_we_s;
                    addr_d       = sel_addr_s;
                    wdata_d      = sel_wdata_s;
                    cnt_d        = CNT_LOAD;
                    mem_read_d   = ~sel_we_s;
                    mem_write_d  = sel_we_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == cnt_t'(0)) begin
                    state_d    = ST_RESP;
                    cpu_done_d = (owner_q == REQ_CPU);
                    sys_done_d = (owner_q == REQ_SYS);
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d      = cnt_q - cnt_t'(1);
                    mem_read_d = ~we_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves SYS as last grant so the CPU wins the first tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= REQ_CPU;
            we_q         <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            cnt_q        <= cnt_t'(0);
            last_grant_q <= REQ_SYS;
            rdata_q      <= {DATA_W{1'b0}};
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            cpu_done_q   <= 1'b0;
            sys_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            rdata_q      <= rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            cpu_done_q   <= cpu_done_d;
            sys_done_q   <= sys_done_d;
        end
    end

    assign cpu_done  = cpu_done_q;
    assign sys_done  = sys_done_q;
    assign rdata     = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign cpu_stall = cpu_req & ~cpu_done_q;

endmodule
